// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle shifter for the ALU shift path. Instead of a full barrel
// shifter, the operand is shifted by at most STEP bits per clock until the
// requested amount has been consumed. A start/busy/done handshake lets the
// control unit stall while the shift completes.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 8)
//   STEP   maximum bits shifted per clock (power of two, 1..WIDTH)
//   CNT_W  width of the remaining-count register (derived, not overridable)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request; accepted on an edge where busy=0 (IDLE or DONE)
//   mode     00 SLL, 01 SRL, 10 SRA, 11 ROR (or SRL, see below)
//   data_in  operand, sampled on the accept edge
//   shamt    unsigned shift amount, sampled on the accept edge
//   busy     high while a shift is in progress
//   done     one-cycle pulse, result valid
//   result   shifted value, held until the next accept or reset
//
// Build option:
//   SEQ_SHIFTER_ROTATE_EN  when defined, mode 11 is rotate-right. When
//                          undefined, the rotate path is not built and
//                          mode 11 behaves exactly like SRL.
// -----------------------------------------------------------------------------
module seq_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic [1:0] M_ROR = 2'b11;
`endif

  localparam logic [CNT_W-1:0] WIDTH_C   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] SRA_MAX_C = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       op;
  logic [1:0]       op_next;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_next;
  logic [CNT_W-1:0] step_k;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] result_next;

  // Saturate the 32-bit request to the amount that actually changes the
  // operand. All shamt bits take part in the comparison, so huge amounts
  // clamp instead of wrapping. Shifting right arithmetically by WIDTH-1
  // already yields pure sign bits, so SRA stops there.
  function automatic logic [CNT_W-1:0] eff_amount(input logic [1:0]  m,
                                                  input logic [31:0] s);
    logic [CNT_W-1:0] n;
    n = '0;
    case (m)
      M_SRA:   n = (s >= 32'(WIDTH - 1)) ? SRA_MAX_C : s[CNT_W-1:0];
`ifdef SEQ_SHIFTER_ROTATE_EN
      M_ROR:   n = {1'b0, s[SH_W-1:0]};
`endif
      default: n = (s >= 32'(WIDTH)) ? WIDTH_C : s[CNT_W-1:0];
    endcase
    return n;
  endfunction

  // Without the rotate option mode 11 is folded into SRL at accept time so
  // the per-step datapath never sees it.
  function automatic logic [1:0] decode_mode(input logic [1:0] m);
`ifdef SEQ_SHIFTER_ROTATE_EN
    return m;
`else
    return (m == 2'b11) ? M_SRL : m;
`endif
  endfunction

  // One partial shift by k (0 < k <= STEP). k never exceeds the remaining
  // amount, so for ROR it stays below WIDTH and WIDTH-k is a legal shift.
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0]       m,
                                                  input logic [WIDTH-1:0] v,
                                                  input logic [CNT_W-1:0] k);
    logic signed [WIDTH-1:0] sv;
    logic        [WIDTH-1:0] r;
    sv = $signed(v);
    r  = v;
    case (m)
      M_SLL:   r = v << k;
      M_SRA:   r = $unsigned(sv >>> k);
`ifdef SEQ_SHIFTER_ROTATE_EN
      M_ROR:   r = (v >> k) | (v << (WIDTH_C - k));
`endif
      default: r = v >> k;
    endcase
    return r;
  endfunction

  // State and datapath registers. The result register is cleared on reset so
  // it never carries X into the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= M_SLL;
      rem    <= '0;
      result <= '0;
    end else begin
      state  <= state_next;
      op     <= op_next;
      rem    <= rem_next;
      result <= result_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next  = state;
    op_next     = op;
    rem_next    = rem;
    result_next = result;
    amount      = eff_amount(mode, shamt);
    step_k      = (rem > STEP_C) ? STEP_C : rem;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          result_next = data_in;
          op_next     = decode_mode(mode);
          rem_next    = amount;
          state_next  = (amount != '0) ? SHIFT : DONE;
        end else begin
          state_next  = IDLE;
        end
      end
      SHIFT: begin
        result_next = shift_step(op, result, step_k);
        rem_next    = rem - step_k;
        state_next  = (rem == step_k) ? DONE : SHIFT;
      end
      default: begin
        state_next  = IDLE;
      end
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
//
// Directed bench for seq_shifter with WIDTH=32, STEP=4. Expected values are
// hand-computed; mode 11 expectations follow SEQ_SHIFTER_ROTATE_EN.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] data_in;
  logic [31:0] shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  seq_shifter #(
    .WIDTH(32),
    .STEP (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .data_in(data_in),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op from an idle/done state and follow it to its done pulse.
  // exp_edge counts the accept edge as edge 1.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] d,
                        input logic [31:0] s, input logic [31:0] exp_res,
                        input int exp_edge, input int exp_busy);
    int edges;
    int bcnt;
    mode = m; data_in = d; shamt = s; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    bcnt  = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) bcnt++;
      tick();
      edges++;
    end
    check({tag, " done_edge"}, edges, exp_edge);
    check({tag, " result"}, result, exp_res);
    check({tag, " busy_cycles"}, bcnt, exp_busy);
    tick();
    check({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
    check({tag, " result_held"}, result, exp_res);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; mode = 2'b00; data_in = '0; shamt = '0;
    tick();
    // reset must win over a concurrent start
    start = 1'b1; mode = 2'b00; data_in = 32'hDEAD_BEEF; shamt = 32'd4;
    tick();
    start = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    tick();
    check("idle result", result, 32'd0);

    // single-step SRA of a negative value
    run_op("sra_neg_4", 2'b10, 32'h8000_0000, 32'd4, 32'hF800_0000, 2, 1);
    // SRL clamps to WIDTH
    run_op("srl_35", 2'b01, 32'hF000_0000, 32'd35, 32'h0000_0000, 9, 8);
    // SRA clamps to WIDTH-1
    run_op("sra_35", 2'b10, 32'h8000_0000, 32'd35, 32'hFFFF_FFFF, 9, 8);
    // zero amount goes straight to DONE
    run_op("sll_0", 2'b00, 32'h0000_0001, 32'd0, 32'h0000_0001, 1, 0);
    // mode 11
`ifdef SEQ_SHIFTER_ROTATE_EN
    run_op("ror_33", 2'b11, 32'h0000_0001, 32'd33, 32'h8000_0000, 2, 1);
    run_op("ror_36", 2'b11, 32'h1234_5678, 32'd36, 32'h8123_4567, 2, 1);
`else
    run_op("ror_33", 2'b11, 32'h0000_0001, 32'd33, 32'h0000_0000, 9, 8);
    run_op("ror_36", 2'b11, 32'h1234_5678, 32'd36, 32'h0000_0000, 9, 8);
`endif
    // multi-step SLL with partial last step, SLL by exactly WIDTH, positive SRA
    run_op("sll_7", 2'b00, 32'h1234_5678, 32'd7, 32'h1A2B_3C00, 3, 2);
    run_op("sll_32", 2'b00, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 9, 8);
    run_op("sra_pos_40", 2'b10, 32'h7FFF_FFFF, 32'd40, 32'h0000_0000, 9, 8);
    run_op("sra_huge", 2'b10, 32'h8765_4321, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 8);

    // start while busy is ignored; start in DONE is accepted with no bubble
    mode = 2'b00; data_in = 32'h0000_0001; shamt = 32'd8; start = 1'b1;
    tick();
    check("b2b busy1", {31'd0, busy}, 32'd1);
    mode = 2'b01; data_in = 32'hFFFF_FFFF; shamt = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b ignored result", result, 32'h0000_0010);
    check("b2b still busy", {31'd0, busy}, 32'd1);
    tick();
    check("b2b done1", {31'd0, done}, 32'd1);
    check("b2b result1", result, 32'h0000_0100);
    mode = 2'b01; data_in = 32'h0000_0100; shamt = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b no bubble busy", {31'd0, busy}, 32'd1);
    check("b2b no bubble done", {31'd0, done}, 32'd0);
    tick();
    check("b2b done2", {31'd0, done}, 32'd1);
    check("b2b result2", result, 32'h0000_0010);
    tick();
    check("b2b idle", {30'd0, busy, done}, 32'd0);

    // reset on the third SHIFT edge aborts without a done pulse
    mode = 2'b01; data_in = 32'hFFFF_FFFF; shamt = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort mid result", result, 32'h0FFF_FFFF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    seen_done = 1'b0;
    repeat (6) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    check("abort no done", {31'd0, seen_done}, 32'd0);
    check("abort result idle", result, 32'd0);
    run_op("after_abort", 2'b00, 32'h0000_0003, 32'd5, 32'h0000_0060, 3, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
